salsa_feeder: RTL and testbench
===============================

SALSA_FEEDER -- requirements
Module: salsa_feeder

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 run  input  1  level; 1 = keep generating blocks, 0 = stop at next block boundary.
REQ-004 cfg_we  input  1  config write strobe.
REQ-005 cfg_addr  input  4  word index: 0-7 key[0..7], 8-9 nonce[0..1], 10 pos[0] (low), 11 pos[1] (high); 12-15 ignored.
REQ-006 cfg_data  input  32  config write data.
REQ-007 core_start  output  1  start strobe to hash core.
REQ-008 core_data  output  32  word stream to hash core.
REQ-009 core_ready  input  1  hash core idle.
REQ-010 core_writes  input  1  hash core emitting keystream bytes.
REQ-011 core_byte  input  8  keystream byte from hash core.
REQ-012 pt_valid / pt_ready / pt_data  in / out / in  1/1/8  plaintext byte handshake.
REQ-013 ct_valid / ct_ready / ct_data  out / in / out  1/1/8  ciphertext byte handshake.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 States: IDLE, LOAD, WAIT, CAPTURE, DRAIN; the state register is the only control state plus counters.
REQ-016 IDLE: cfg_we writes the addressed register; IDLE -> LOAD when run=1 and core_ready=1.
REQ-017 cfg_we outside IDLE is ignored, with no register change.
REQ-018 LOAD lasts exactly 12 consecutive cycles, no gaps.
- Cycle 0: core_start=1, core_data=key[0].
- Cycles 1-11: core_data = key[1..7], nonce[0], nonce[1], pos[0], pos[1] in that order; core_start=0.
REQ-019 After LOAD -> WAIT; core_data=0 and core_start=0 in all non-LOAD cycles.
REQ-020 WAIT -> CAPTURE on the first cycle core_writes=1; that cycle's core_byte is keystream byte 0.
REQ-021 CAPTURE stores core_byte into ks_buf[n] for each of 64 consecutive core_writes=1 cycles (n=0..63), then -> DRAIN.
REQ-022 A core_writes low cycle inside CAPTURE does not advance n.
REQ-023 core_writes=1 in IDLE, LOAD or DRAIN is ignored.
REQ-024 DRAIN handshake:
- pt_ready = 1 iff state==DRAIN and (ct_valid==0 or ct_ready==1).
- On pt_valid&pt_ready, next cycle: ct_data = pt_data XOR ks_buf[rd], ct_valid=1, rd increments.
REQ-025 ct_valid holds with ct_data stable until ct_ready=1; simultaneous ct_ready and a new pt accept replaces the output word with no bubble.
REQ-026 Once rd reaches 64 (the 64th byte accepted), the block is done:
- 64-bit {pos[1],pos[0]} increments by 1, wrapping 0xFFFFFFFF_FFFFFFFF -> 0.
- rd and n clear; -> LOAD if run=1 and core_ready=1, else IDLE.
REQ-027 Pending ct_valid may complete after leaving DRAIN; no new pt is accepted until next DRAIN.
REQ-028 Throughput: one byte per cycle in DRAIN with pt_valid=1 and ct_ready=1.

Reset
REQ-029 reset=1 at any time, mid-LOAD/CAPTURE/DRAIN included, forces next-cycle IDLE, counters 0, ct_valid=0, ct_data=0, pt_ready=0, core_start=0, core_data=0, busy=0.
REQ-030 reset clears key, nonce, pos and ks_buf to 0; reset has priority over cfg_we and run.
REQ-031 The hash core is reset from the same reset net; no partial block survives reset.

Configuration
REQ-032 Macro SALSA_FEEDER_POS_AUTOINC_EN:
- Defined: REQ-026 position increment applies.
- Undefined: pos is unchanged after a block and changes only via cfg writes; all other behaviour is identical.

Verification
REQ-033 Set key[i]=0x11111111*(i+1), nonce={0xA0A0A0A0,0xB0B0B0B0}, pos={0,0}, run=1 -> core_start for 1 cycle; core_data sequence 0x11111111..0x88888888, 0xA0A0A0A0, 0xB0B0B0B0, 0, 0 on 12 consecutive cycles.
REQ-034 Core stub emits bytes 0x00..0x3F, pt 64x 0xFF, ct_ready=1 -> ct_data 0xFF..0xC0 in order, one per cycle, 64 outputs.
REQ-035 pos={0xFFFFFFFF,0xFFFFFFFF}, one block with macro defined -> next LOAD sends pos words 0,0; macro undefined -> sends 0xFFFFFFFF twice.
REQ-036 ct_ready held 0 for 5 cycles mid-DRAIN -> pt_ready=0 after first ct, ct_data stable, no byte lost or duplicated.
REQ-037 reset asserted on LOAD cycle 5 -> IDLE next cycle, all outputs 0; cfg_we during busy -> register unchanged on readback via next LOAD.

Source files
------------

// File: rtl/salsa_feeder.sv
// salsa_feeder: streams key/nonce/pos into a hash core, buffers its 64-byte keystream, XORs plaintext.
// Define SALSA_FEEDER_POS_AUTOINC_EN to advance the 64-bit block position after every block.
module salsa_feeder (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  output logic        core_start,
  output logic [31:0] core_data,
  input  logic        core_ready,
  input  logic        core_writes,
  input  logic [7:0]  core_byte,
  input  logic        pt_valid,
  output logic        pt_ready,
  input  logic [7:0]  pt_data,
  output logic        ct_valid,
  input  logic        ct_ready,
  output logic [7:0]  ct_data,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAPTURE, DRAIN} state_t;
  state_t state, state_nxt;
  logic [3:0] ld_cnt;
  logic [5:0] n, rd;
  // cfg words are kept in core load order: key[0..7], nonce[0..1], pos low, pos high
  logic [31:0] cfg [12];
  logic [7:0] ks_buf [64];
  logic take, done, cap;
  assign take = pt_valid & pt_ready;
  assign done = take & (rd == 6'd63);
  assign cap = core_writes & (state == WAIT | state == CAPTURE);
  always_comb begin
    state_nxt = state;
    core_start = state == LOAD && ld_cnt == 4'd0;
    core_data = state == LOAD ? cfg[ld_cnt] : '0;
    pt_ready = state == DRAIN && (!ct_valid || ct_ready);
    busy = state != IDLE;
    case (state)
      IDLE:    state_nxt = run && core_ready ? LOAD : IDLE;
      LOAD:    state_nxt = ld_cnt == 4'd11 ? WAIT : LOAD;
      WAIT:    state_nxt = core_writes ? CAPTURE : WAIT;
      CAPTURE: state_nxt = core_writes && n == 6'd63 ? DRAIN : CAPTURE;
      DRAIN:   state_nxt = done ? (run && core_ready ? LOAD : IDLE) : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // n and rd are 6 bits so the 64th byte wraps them back to 0 for the next block
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ld_cnt <= '0;
      n <= '0;
      rd <= '0;
      ct_valid <= 1'b0;
      ct_data <= '0;
      for (int i = 0; i < 12; i++) cfg[i] <= '0;
      for (int i = 0; i < 64; i++) ks_buf[i] <= '0;
    end else begin
      state <= state_nxt;
      ld_cnt <= state == LOAD && ld_cnt != 4'd11 ? ld_cnt + 4'd1 : 4'd0;
      if (state == IDLE && cfg_we && cfg_addr < 4'd12) cfg[cfg_addr] <= cfg_data;
      if (cap) begin
        ks_buf[n] <= core_byte;
        n <= n + 6'd1;
      end
      if (take) begin
        ct_data <= pt_data ^ ks_buf[rd];
        rd <= rd + 6'd1;
      end
      ct_valid <= take | (ct_valid & ~ct_ready);
`ifdef SALSA_FEEDER_POS_AUTOINC_EN
      if (done) {cfg[11], cfg[10]} <= {cfg[11], cfg[10]} + 64'd1;
`else
`endif
    end
  end
endmodule

// File: tb/tb_salsa_feeder.sv
// tb_salsa_feeder: randomized scoreboard bench with a hash-core stub and a queue-based keystream model.
module tb_salsa_feeder;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic core_start, pt_ready, ct_valid, busy;
  logic [31:0] core_data;
  logic core_ready = 1'b1, core_writes = 1'b0, pt_valid = 1'b0, ct_ready = 1'b0;
  logic [7:0] core_byte = '0, pt_data = '0, ct_data;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] key_m [8];
  logic [31:0] nonce_m [2];
  logic [63:0] pos_m;
  logic [31:0] exp_load [$];
  logic [7:0] ks_q [$], exp_ct [$], ct_log [$];
  int ct_t [$];
  int load_seen = 0, pt_acc = 0, lpos = 0, stall = 0, stall_at = -1;
  int ph = 0, cnt = 0, lat = 0, b = 0, base_ct = 0;
  bit directed = 1'b0, hold = 1'b0;
  logic [7:0] hold_d;

  salsa_feeder dut (
    .clk(clk), .reset(reset), .run(run), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .core_start(core_start), .core_data(core_data), .core_ready(core_ready), .core_writes(core_writes),
    .core_byte(core_byte), .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s at cycle %0d", name, what, cyc);
  endtask

  task automatic cfg_write(input int a, input logic [31:0] d, input bit model);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a[3:0]; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (model) begin
      if (a < 8) key_m[a] = d;
      else if (a < 10) nonce_m[a-8] = d;
      else if (a == 10) pos_m[31:0] = d;
      else if (a == 11) pos_m[63:32] = d;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) key_m[i] = '0;
    nonce_m[0] = '0; nonce_m[1] = '0; pos_m = '0;
  endtask

  task automatic push_load();
    for (int i = 0; i < 8; i++) exp_load.push_back(key_m[i]);
    exp_load.push_back(nonce_m[0]);
    exp_load.push_back(nonce_m[1]);
    exp_load.push_back(pos_m[31:0]);
    exp_load.push_back(pos_m[63:32]);
`ifdef SALSA_FEEDER_POS_AUTOINC_EN
    pos_m = pos_m + 64'd1;
`else
`endif
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || ct_valid || exp_ct.size() != 0) && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 3000) fail("idle_timeout", "block did not drain, required idle within 3000 cycles");
    check("ks_leftover", 32'(ks_q.size()), 0);
  endtask

  task automatic run_blocks(input int nb);
    int base = load_seen, t = 0;
    for (int i = 0; i < nb; i++) push_load();
    @(posedge clk); #1;
    run = 1'b1;
    while (load_seen < base + nb && t < 3000 * nb) begin
      @(posedge clk); #1; t++;
    end
    run = 1'b0;
    if (t >= 3000 * nb) fail("load_timeout", "too few LOAD starts");
    wait_idle();
    check("load_leftover", 32'(exp_load.size()), 0);
  endtask

  // LOAD word stream checker; outside LOAD the core bus must be quiet
  always @(negedge clk) begin
    if (reset) lpos = 0;
    else if (core_start || lpos > 0) begin
      if (lpos == 0) load_seen++;
      else check("core_start_len", 32'(core_start), 0);
      if (exp_load.size() == 0) fail("load_unexpected", "core word with nothing expected");
      else check("core_data", core_data, exp_load.pop_front());
      lpos = lpos == 11 ? 0 : lpos + 1;
    end else begin
      check("idle_core_start", 32'(core_start), 0);
      check("idle_core_data", core_data, 0);
    end
  end

  // hash core stub: consumes the 12-word load, then emits 64 bytes with optional gaps
  initial forever begin
    @(posedge clk); #2;
    if (reset) begin
      ph = 0; core_ready = 1'b1; core_writes = 1'b0;
    end else if (ph == 0) begin
      core_writes = 1'b0; core_ready = 1'b1;
      if (core_start) begin
        ph = 1; cnt = 0; core_ready = 1'b0;
        lat = directed ? 0 : $urandom_range(0, 6);
      end
    end else if (ph == 1) begin
      cnt++;
      if (cnt >= 12 + lat) begin ph = 2; b = 0; end
    end else if (b == 64) begin
      core_writes = 1'b0; core_ready = 1'b1; ph = 0;
    end else begin
      core_writes = directed || $urandom_range(0, 3) != 0;
      if (core_writes) begin
        core_byte = directed ? 8'(b) : 8'($urandom);
        ks_q.push_back(core_byte);
        b++;
      end
    end
  end

  // plaintext / ciphertext-ready driver
  initial forever begin
    @(posedge clk); #1;
    if (directed) begin
      pt_valid = 1'b1; pt_data = 8'hFF; ct_ready = 1'b1;
    end else begin
      pt_valid = $urandom_range(0, 3) != 0;
      pt_data = 8'($urandom);
      if (stall_at >= 0 && pt_acc >= stall_at) begin stall = 5; stall_at = -1; end
      if (stall > 0) begin ct_ready = 1'b0; stall--; end
      else ct_ready = $urandom_range(0, 2) != 0;
    end
  end

  // expected ciphertext = plaintext XOR next keystream byte in arrival order
  always @(negedge clk) begin
    if (!reset && pt_valid && pt_ready) begin
      pt_acc++;
      if (ks_q.size() == 0) fail("ks_underflow", "pt accepted before 64 keystream bytes");
      else exp_ct.push_back(pt_data ^ ks_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (hold) begin
      check("ct_hold_valid", 32'(ct_valid), 1);
      check("ct_hold_data", 32'(ct_data), 32'(hold_d));
    end
    if (ct_valid && !ct_ready) check("pt_ready_stall", 32'(pt_ready), 0);
    if (!busy) check("pt_ready_idle", 32'(pt_ready), 0);
    if (ct_valid && ct_ready) begin
      ct_log.push_back(ct_data);
      ct_t.push_back(cyc);
      if (exp_ct.size() == 0) fail("ct_unexpected", $sformatf("got %h with nothing expected", ct_data));
      else check("ct_data", 32'(ct_data), 32'(exp_ct.pop_front()));
    end
    hold = ct_valid && !ct_ready && !reset;
    hold_d = ct_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_ct_valid", 32'(ct_valid), 0);
    check("rst_ct_data", 32'(ct_data), 0);
    check("rst_pt_ready", 32'(pt_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) cfg_write(i, 32'h11111111 * (i + 1), 1'b1);
    cfg_write(8, 32'hA0A0A0A0, 1'b1);
    cfg_write(9, 32'hB0B0B0B0, 1'b1);
    cfg_write(10, 32'h0, 1'b1);
    cfg_write(11, 32'h0, 1'b1);
    directed = 1'b1;
    base_ct = ct_log.size();
    run_blocks(1);
    directed = 1'b0;
    check("dir_count", 32'(ct_log.size() - base_ct), 64);
    check("dir_first", 32'(ct_log[base_ct]), 32'hFF);
    check("dir_last", 32'(ct_log[base_ct+63]), 32'hC0);
    check("dir_rate", 32'(ct_t[base_ct+63] - ct_t[base_ct]), 63);
    for (int i = 0; i < 12; i++) cfg_write(i, $urandom, 1'b1);
    stall_at = pt_acc + 20;
    fork
      run_blocks(3);
      begin
        int t = 0;
        while (!busy && t < 200) begin @(posedge clk); #1; t++; end
        repeat (20) @(posedge clk);
        cfg_write(0, 32'hDEADBEEF, 1'b0);
        cfg_write(11, 32'h12345678, 1'b0);
      end
    join
    cfg_write(12, 32'hCAFEF00D, 1'b1);
    cfg_write(15, 32'h0BADF00D, 1'b1);
    cfg_write(10, 32'hFFFFFFFF, 1'b1);
    cfg_write(11, 32'hFFFFFFFF, 1'b1);
    run_blocks(2);
    begin
      int t = 0;
      push_load();
      @(posedge clk); #1;
      run = 1'b1;
      while (!core_start && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) fail("start_timeout", "no core_start");
      run = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_load.delete(); ks_q.delete(); exp_ct.delete();
      model_clear();
      @(negedge clk);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_start", 32'(core_start), 0);
      check("mid_rst_data", core_data, 0);
      check("mid_rst_ct_valid", 32'(ct_valid), 0);
      check("mid_rst_ct_data", 32'(ct_data), 0);
      check("mid_rst_pt_ready", 32'(pt_ready), 0);
    end
    run_blocks(1);
    check("ct_leftover", 32'(exp_ct.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
